// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// Transmit-only UART with a small word FIFO in front of the serialiser.
// Bit timing comes from a clk-domain divider (CLK_HZ/BAUD) used as an enable.
// Frame: start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset
//   s_data     : word to transmit, captured on an accepting edge
//   s_valid    : s_data valid
//   s_ready    : FIFO can accept a word (low while in reset or full)
//   tx         : serial line, registered, idle high
//   busy       : registered, high while a frame is on the line
//   fifo_count : words currently held in the FIFO (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module uart_tx_core #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV    = CLK_HZ / BAUD;
   localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BIT_W  = 3;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
   localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
   localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]    CNT_ZERO  = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

   // Illegal configurations stop elaboration.
   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_core: CLK_HZ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_core: DATA_BITS must be 5..8");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_core: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_core: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_core: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      logic p;
      p = ^d;
      if (PARITY == 2) begin
         p = ~p;
      end else begin
         p = p;
      end
      return p;
   endfunction

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [PTR_W:0]       count_q;
   logic [PTR_W:0]       count_d;

   state_e               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 tx_q;
   logic                 busy_q;

   logic                 push_s;
   logic                 pop_s;
   logic                 tick_s;
   logic                 frame_end_s;
   logic [DATA_BITS-1:0] head_s;

   // Ready depends only on the current count, so a full FIFO never takes a
   // word even on an edge where the serialiser pops.
   assign s_ready    = rst_n && (count_q < CNT_FULL);
   assign push_s     = s_valid && s_ready;
   assign head_s     = mem_q[rd_ptr_q];
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   // Baud tick, end-of-frame detect and pop request.
   always_comb begin
      tick_s      = (baud_q == BAUD_LAST);
      frame_end_s = (state_q == S_STOP) && tick_s && (bit_q == STOP_LAST);
      if (count_q != CNT_ZERO) begin
         pop_s = (state_q == S_IDLE) || frame_end_s;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write; contents need no reset, pointers gate validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q <= count_d;
      end
   end

   // Frame FSM with registered tx/busy and the baud divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= BAUD_ZERO;
         bit_q   <= BIT_ZERO;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               baud_q <= BAUD_ZERO;
               if (pop_s) begin
                  shift_q <= head_s;
                  par_q   <= parity_of(head_s);
                  bit_q   <= BIT_ZERO;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end else begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            S_START: begin
               if (tick_s) begin
                  baud_q  <= BAUD_ZERO;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= BIT_ZERO;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_ONE;
               end
            end
            S_DATA: begin
               if (tick_s) begin
                  baud_q <= BAUD_ZERO;
                  if (bit_q == DATA_LAST) begin
                     bit_q <= BIT_ZERO;
                     if (PARITY != 0) begin
                        tx_q    <= par_q;
                        state_q <= S_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                     end
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + BIT_ONE;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_ONE;
               end
            end
            S_PARITY: begin
               if (tick_s) begin
                  baud_q  <= BAUD_ZERO;
                  bit_q   <= BIT_ZERO;
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
               end else begin
                  baud_q <= baud_q + BAUD_ONE;
               end
            end
            S_STOP: begin
               if (tick_s) begin
                  baud_q <= BAUD_ZERO;
                  if (bit_q == STOP_LAST) begin
                     bit_q <= BIT_ZERO;
                     // Queued word goes straight into a new start bit.
                     if (pop_s) begin
                        shift_q <= head_s;
                        par_q   <= parity_of(head_s);
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                     end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end
                  end else begin
                     bit_q <= bit_q + BIT_ONE;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               baud_q  <= BAUD_ZERO;
               bit_q   <= BIT_ZERO;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core at CLK_HZ=1_000_000, BAUD=100_000 (10 clk/bit).
// Four instances: 8N1, 8E1, 8O1 and 7E2, sharing clock and reset.
module tb_uart_tx_core;

   logic clk;
   logic rst_n;

   logic       v0, v1, v2, v3;
   logic [7:0] d0, d1, d2;
   logic [6:0] d3;
   logic       rdy0, rdy1, rdy2, rdy3;
   logic       tx0, tx1, tx2, tx3;
   logic       bz0, bz1, bz2, bz3;
   logic [2:0] cnt0, cnt1, cnt2, cnt3;

   int total;
   int bad;

   uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .s_data(d0), .s_valid(v0), .s_ready(rdy0),
      .tx(tx0), .busy(bz0), .fifo_count(cnt0));

   uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .s_data(d1), .s_valid(v1), .s_ready(rdy1),
      .tx(tx1), .busy(bz1), .fifo_count(cnt1));

   uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .s_data(d2), .s_valid(v2), .s_ready(rdy2),
      .tx(tx2), .busy(bz2), .fifo_count(cnt2));

   uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
      .clk(clk), .rst_n(rst_n), .s_data(d3), .s_valid(v3), .s_ready(rdy3),
      .tx(tx3), .busy(bz3), .fifo_count(cnt3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [11:0] exp;   // bit i = i-th line bit (start first)
      int         nbits;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv(input int sel, input logic v, input logic [7:0] data);
      case (sel)
         0: begin v0 = v; d0 = data; end
         1: begin v1 = v; d1 = data; end
         2: begin v2 = v; d2 = data; end
         3: begin v3 = v; d3 = data[6:0]; end
         default: ;
      endcase
   endtask

   function automatic logic tx_of(input int sel);
      case (sel)
         0: return tx0;
         1: return tx1;
         2: return tx2;
         3: return tx3;
         default: return 1'bx;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      case (sel)
         0: return bz0;
         1: return bz1;
         2: return bz2;
         3: return bz3;
         default: return 1'bx;
      endcase
   endfunction

   // Push one word into an idle instance and check the whole frame cycle by cycle.
   task automatic frame_check(input int idx, input int sel, input logic [7:0] data,
                              input logic [11:0] exp, input int nbits);
      int bit_bad;
      int busy_bad;
      drv(sel, 1'b1, data);
      @(negedge clk);
      drv(sel, 1'b0, 8'h00);
      chk($sformatf("vec%0d_idle_after_accept", idx), tx_of(sel), 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_start_latency", idx), tx_of(sel), 1'b0);
      bit_bad  = 0;
      busy_bad = 0;
      for (int k = 0; k < nbits * 10; k++) begin
         if (tx_of(sel) !== exp[k / 10]) bit_bad++;
         if (busy_of(sel) !== 1'b1) busy_bad++;
         @(negedge clk);
      end
      chk($sformatf("vec%0d_line_bits", idx), bit_bad, 0);
      chk($sformatf("vec%0d_busy_during", idx), busy_bad, 0);
      chk($sformatf("vec%0d_tx_after", idx), tx_of(sel), 1'b1);
      chk($sformatf("vec%0d_busy_after", idx), busy_of(sel), 1'b0);
   endtask

   // Decode one 8N1 frame from tx0 by mid-bit sampling; ok=0 on timeout or bad stop.
   task automatic rx_byte(output logic [7:0] b, output logic ok);
      int n;
      n  = 0;
      b  = 8'h00;
      ok = 1'b0;
      while (tx0 !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (tx0 === 1'b0) begin
         repeat (5) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = tx0;
         end
         repeat (10) @(negedge clk);
         ok = (tx0 === 1'b1);
      end
   endtask

   logic [7:0] words [6];
   logic       line [600];
   logic [7:0] got [4];
   logic       ok [4];
   logic [7:0] wq [4];

   initial begin
      int   idx, n_acc, s, lbad, bbad;
      logic started, acc;

      total = 0;
      bad   = 0;
      vecs[0] = '{0, 8'h41, 12'b00_1010000010, 10};
      vecs[1] = '{0, 8'h00, 12'b00_1000000000, 10};
      vecs[2] = '{0, 8'hFF, 12'b00_1111111110, 10};
      vecs[3] = '{0, 8'hA5, 12'b00_1101001010, 10};
      vecs[4] = '{1, 8'h41, 12'b0_10010000010, 11};
      vecs[5] = '{2, 8'h41, 12'b0_11010000010, 11};
      vecs[6] = '{1, 8'h07, 12'b0_11000001110, 11};
      vecs[7] = '{3, 8'h41, 12'b0_11010000010, 11};
      vecs[8] = '{3, 8'h55, 12'b0_11010101010, 11};

      rst_n = 1'b0;
      drv(0, 1'b0, 8'h00); drv(1, 1'b0, 8'h00); drv(2, 1'b0, 8'h00); drv(3, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk("reset_ready_low", rdy0, 1'b0);
      chk("reset_tx_high", tx0, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_tx", tx0, 1'b1);
      chk("rel_busy", bz0, 1'b0);
      chk("rel_count", cnt0, 3'd0);
      chk("rel_ready", rdy0, 1'b1);
      chk("rel_ready_7e2", rdy3, 1'b1);

      for (int i = 0; i < 9; i++) begin
         frame_check(i, vecs[i].sel, vecs[i].data, vecs[i].exp, vecs[i].nbits);
         repeat (3) @(negedge clk);
      end

      // Six words with s_valid held: FIFO fills, frames run back to back.
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
      for (int f = 0; f < 6; f++)
         for (int b = 0; b < 10; b++)
            for (int c = 0; c < 10; c++)
               line[f*100 + b*10 + c] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : words[f][b-1];
      idx = 0; n_acc = 0; s = 0; lbad = 0; bbad = 0; started = 1'b0;
      drv(0, 1'b1, words[0]);
      for (int cyc = 0; cyc < 800; cyc++) begin
         acc = v0 && rdy0;
         if (!started && tx0 === 1'b0) begin
            started = 1'b1;
            s = cyc;
         end
         if (started && (cyc - s) < 600) begin
            if (tx0 !== line[cyc - s]) lbad++;
            if (bz0 !== 1'b1) bbad++;
         end
         if (started && (cyc - s) == 99) begin
            chk("b2b_accepted_before_end", n_acc, 5);
            chk("b2b_full_count", cnt0, 3'd4);
            chk("b2b_full_ready", rdy0, 1'b0);
         end
         if (started && (cyc - s) == 101) begin
            chk("b2b_sixth_accepted", n_acc, 6);
            chk("b2b_count_refill", cnt0, 3'd4);
         end
         if (started && (cyc - s) == 600) begin
            chk("b2b_tx_idle", tx0, 1'b1);
            chk("b2b_busy_low", bz0, 1'b0);
            chk("b2b_count_empty", cnt0, 3'd0);
         end
         @(negedge clk);
         if (acc) begin
            n_acc++;
            idx++;
            if (idx < 6) drv(0, 1'b1, words[idx]);
            else drv(0, 1'b0, 8'h00);
         end
      end
      chk("b2b_started", started, 1'b1);
      chk("b2b_line", lbad, 0);
      chk("b2b_busy", bbad, 0);
      chk("b2b_total_accepted", n_acc, 6);

      // Push coincident with a pop at fifo_count=2; order must be preserved.
      wq[0] = 8'hC1; wq[1] = 8'h3E; wq[2] = 8'h5B; wq[3] = 8'h96;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               logic [7:0] b;
               logic       o;
               rx_byte(b, o);
               got[i] = b;
               ok[i]  = o;
            end
         end
         begin
            drv(0, 1'b1, wq[0]); @(negedge clk);
            drv(0, 1'b1, wq[1]); @(negedge clk);
            drv(0, 1'b1, wq[2]); @(negedge clk);
            drv(0, 1'b0, 8'h00);
            chk("pp_count_pre", cnt0, 3'd2);
            repeat (98) @(negedge clk);
            chk("pp_count_before_edge", cnt0, 3'd2);
            drv(0, 1'b1, wq[3]);
            @(negedge clk);
            drv(0, 1'b0, 8'h00);
            chk("pp_count_same_cycle", cnt0, 3'd2);
         end
      join
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pp_order_%0d", i), got[i], wq[i]);
         chk($sformatf("pp_stop_%0d", i), ok[i], 1'b1);
      end
      repeat (10) @(negedge clk);
      chk("pp_drained", cnt0, 3'd0);
      chk("pp_busy_low", bz0, 1'b0);

      // Reset during data bit 3 with two words still queued.
      drv(0, 1'b1, 8'h00); @(negedge clk);
      drv(0, 1'b1, 8'hAA); @(negedge clk);
      drv(0, 1'b1, 8'hBB); @(negedge clk);
      drv(0, 1'b0, 8'h00);
      repeat (44) @(negedge clk);
      chk("mid_tx_low", tx0, 1'b0);
      chk("mid_busy", bz0, 1'b1);
      chk("mid_count", cnt0, 3'd2);
      rst_n = 1'b0;
      #1;
      chk("rst_async_tx", tx0, 1'b1);
      chk("rst_async_busy", bz0, 1'b0);
      chk("rst_async_count", cnt0, 3'd0);
      chk("rst_async_ready", rdy0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rel_ready", rdy0, 1'b1);
      repeat (20) @(negedge clk);
      chk("rst_no_leftover_tx", tx0, 1'b1);
      chk("rst_no_leftover_busy", bz0, 1'b0);
      frame_check(9, 0, 8'hC3, 12'b00_1110000110, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO depth in words, power of two and >= 2.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port s_data, input, DATA_BITS, word to transmit.
REQ-010 SHALL have port s_valid, input, 1, s_data valid.
REQ-011 SHALL have port s_ready, output, 1, FIFO can accept a word.
REQ-012 SHALL have port tx, output, 1, serial line, registered, idle high.
REQ-013 SHALL have port busy, output, 1, registered, high while a frame is on the line.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, words currently held in the FIFO.

Function
REQ-015 SHALL compute DIV = CLK_HZ/BAUD, truncated; DIV < 2 or illegal parameter values SHALL stop elaboration.
REQ-016 SHALL time bits with a clk-domain counter 0..DIV-1 used as an enable; no derived clock.
REQ-017 SHALL hold every line bit for exactly DIV clk cycles.
REQ-018 SHALL accept a word on a rising edge where s_valid && s_ready; s_data is captured on that edge.
REQ-019 SHALL drive s_ready = rst_n && (fifo_count < FIFO_DEPTH), using only the current count.
REQ-020 SHALL not accept a write while full, even when a pop occurs in the same cycle.
REQ-021 SHALL leave fifo_count unchanged on a same-cycle push and pop.
REQ-022 SHALL provide FSM states IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE: SHALL drive tx=1 and busy=0; when the FIFO is non-empty, SHALL pop the head word into the shift register, clear the bit counter, drive tx<=0 and busy<=1, and enter START on the same edge.
REQ-024 SHALL make tx low from the edge after the accepting edge when a word is accepted into an empty FIFO in IDLE (1-cycle latency).
REQ-025 START: SHALL hold tx=0 for DIV cycles, then enter DATA.
REQ-026 DATA: SHALL send DATA_BITS bits LSB first, then enter PARITY if PARITY != 0, otherwise STOP.
REQ-027 PARITY: SHALL send even = XOR of the data bits and odd = its inverse, then enter STOP.
REQ-028 STOP: SHALL hold tx=1 for STOP_BITS*DIV cycles.
REQ-029 At the end of STOP with the FIFO non-empty, SHALL pop and enter START directly, with no idle cycle and busy held high.
REQ-030 At the end of STOP with the FIFO empty, SHALL enter IDLE with busy<=0.
REQ-031 SHALL make each frame last exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV cycles.
REQ-032 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with fifo_count in the range 0..FIFO_DEPTH.

Reset
REQ-033 While rst_n=0, SHALL hold tx=1, busy=0, fifo_count=0, s_ready=0, state IDLE, and baud counter 0, asynchronously.
REQ-034 Reset mid-frame SHALL abort the frame, return tx high immediately, and discard FIFO contents.
REQ-035 SHALL assert s_ready=1 in the first cycle after rst_n deasserts.

Verification (CLK_HZ=1_000_000, BAUD=100_000, DIV=10)
REQ-036 Reset release -> tx=1, busy=0, fifo_count=0, s_ready=1.
REQ-037 8N1, push 0x41 -> tx sequence 0,1,0,0,0,0,0,1,0,1, each bit 10 cycles; busy high for 100 cycles.
REQ-038 PARITY=1 then PARITY=2 with 0x41 -> parity bit 0 then 1; DATA_BITS=7, STOP_BITS=2 -> frame 110 cycles.
REQ-039 FIFO_DEPTH=4, s_valid held with 6 words from idle -> 5 accepted, s_ready=0 with fifo_count=4, 6th accepted at first frame end; 6 frames back-to-back in 600 cycles with no tx-high gap beyond the stop bits.
REQ-040 rst_n pulsed low during data bit 3 with 2 words queued -> tx=1, busy=0, fifo_count=0 at once; next push yields a clean full frame.
REQ-041 Push during a pop at fifo_count=2 -> fifo_count stays 2; output word order preserved.
